// File: rtl/spi_tx_queue.sv
// Memory-mapped SPI transmit queue: TX stores are buffered in a FIFO and launched one per controller transfer.
// Optional busy-rise timeout is enabled by defining SPI_TXQ_TIMEOUT_EN.
module spi_tx_queue #(
  parameter int          DEPTH       = 8,
  parameter int          ADDR_W      = 3,
  parameter logic [31:0] TXDATA_ADDR = 32'h0000_0100,
  parameter logic [31:0] CTRL_ADDR   = 32'h0000_0104,
  parameter logic [31:0] STAT_ADDR   = 32'h0000_0108,
  parameter int          BUSY_TO     = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_data,
  input  logic        i_we,
  input  logic        i_spi_busy,
  output logic [31:0] o_spi_data,
  output logic        o_spi_start,
  output logic [31:0] o_rdata,
  output logic        o_full,
  output logic        o_empty,
  output logic        o_overflow,
  output logic        o_timeout
);

`ifdef SPI_TXQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam int             TO_W     = $clog2(BUSY_TO + 1);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t            state;
  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   count_nxt;
  logic [TO_W-1:0]   to_cnt;
  logic [3:0]        cnt4;

  logic push_req, ctrl_wr, flush, clr, pop, push_ok, drop, to_hit;

  assign push_req = i_we && (i_addr == TXDATA_ADDR);
  assign ctrl_wr  = i_we && (i_addr == CTRL_ADDR);
  assign flush    = ctrl_wr && i_data[0];
  assign clr      = ctrl_wr && i_data[1];
  assign pop      = (state == IDLE) && !o_empty && !i_spi_busy;
  // A pop in the same cycle frees a slot, so a full queue still accepts the store.
  assign push_ok  = push_req && !flush && ((count < FULL_CNT) || pop);
  assign drop     = push_req && !flush && !((count < FULL_CNT) || pop);
  assign to_hit   = TO_EN && (state == WAIT_BUSY) && !i_spi_busy &&
                    (to_cnt == TO_W'(BUSY_TO - 1));

  always_comb begin
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else if (push_ok && !pop) begin
      count_nxt = count + 1'b1;
    end else if (pop && !push_ok) begin
      count_nxt = count - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      o_full  <= 1'b0;
      o_empty <= 1'b1;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
        if (pop)     rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      count   <= count_nxt;
      o_full  <= (count_nxt == FULL_CNT);
      o_empty <= (count_nxt == '0);
    end
  end

  // A fresh event in the same cycle as a clear keeps the flag set.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_overflow <= 1'b0;
      o_timeout  <= 1'b0;
    end else begin
      if (drop)     o_overflow <= 1'b1;
      else if (clr) o_overflow <= 1'b0;
      if (to_hit)   o_timeout  <= 1'b1;
      else if (clr) o_timeout  <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= IDLE;
      o_spi_data  <= '0;
      o_spi_start <= 1'b0;
      to_cnt      <= '0;
    end else begin
      o_spi_start <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            o_spi_data  <= mem[rd_ptr];
            o_spi_start <= 1'b1;
            state       <= LAUNCH;
          end
        end
        LAUNCH: begin
          to_cnt <= '0;
          state  <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (i_spi_busy)  state  <= WAIT_DONE;
          else if (to_hit) state  <= IDLE;
          else if (TO_EN)  to_cnt <= to_cnt + TO_W'(1);
        end
        WAIT_DONE: begin
          if (!i_spi_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cnt4    = 4'(count);
  assign o_rdata = (i_addr == STAT_ADDR) ?
                   {20'b0, cnt4, 2'b0, 2'(state), o_timeout, o_overflow, o_full, o_empty} : 32'b0;

endmodule

// File: tb/tb_spi_tx_queue.sv
// Bench for spi_tx_queue: queue-based reference model, scoreboard monitor on o_spi_start, randomized data and controller timing.
module tb_spi_tx_queue;
  localparam logic [31:0] TX = 32'h0000_0100;
  localparam logic [31:0] CT = 32'h0000_0104;
  localparam logic [31:0] ST = 32'h0000_0108;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, data;
  logic        we;
  logic        force_busy, resp_busy, resp_en, resp_fixed;
  logic        busy;
  logic [31:0] spi_data, rdata;
  logic        spi_start, full, empty, ovf, tmo;

  assign busy = force_busy | resp_busy;

  spi_tx_queue dut (
    .i_clk(clk), .i_reset(rst), .i_addr(addr), .i_data(data), .i_we(we),
    .i_spi_busy(busy), .o_spi_data(spi_data), .o_spi_start(spi_start),
    .o_rdata(rdata), .o_full(full), .o_empty(empty), .o_overflow(ovf), .o_timeout(tmo)
  );

  always #5 clk = ~clk;

  int          vec = 0, errs = 0, cyc = 0, last_start = -100, occ = 0;
  logic [31:0] exp_q[$];
  bit          exp_ovf = 0, exp_to = 0;
  logic [31:0] mon_w;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard: every launched word must be the oldest expected one.
  always @(negedge clk) begin
    if (!rst && spi_start) begin
      if (exp_q.size() == 0) begin
        vec++; errs++;
        $display("FAIL unexpected_start: got data %h expected no start (cycle %0d)", spi_data, cyc);
      end else begin
        mon_w = exp_q.pop_front();
        chk("spi_data", spi_data, mon_w);
      end
      chk("start_gap_ge4", 32'(cyc - last_start >= 4), 32'd1);
      last_start = cyc;
    end
  end

  // Controller model: busy rises some cycles after start and holds a while.
  initial begin
    resp_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (resp_en && spi_start && !rst) begin
        repeat (resp_fixed ? 1 : $urandom_range(1, 3)) @(posedge clk);
        #1 resp_busy = 1'b1;
        repeat (resp_fixed ? 10 : $urandom_range(1, 6)) @(posedge clk);
        #1 resp_busy = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr = a; data = d; we = 1'b1;
    tick();
    we = 1'b0; addr = '0; data = '0;
  endtask

  // Model rule: accepted if fewer than 8 queued or a pop happens in the same cycle.
  task automatic push_word(input logic [31:0] d, input bit pop_same);
    if (occ < 8 || pop_same) begin
      exp_q.push_back(d);
      if (!pop_same) occ++;
    end else begin
      exp_ovf = 1'b1;
    end
    store(TX, d);
  endtask

  task automatic check_status(input string nm, input int cnt, input logic [1:0] fsm);
    logic [31:0] e;
    e = '0;
    e[11:8] = cnt[3:0];
    e[5:4]  = fsm;
    e[3]    = exp_to;
    e[2]    = exp_ovf;
    e[1]    = (cnt == 8);
    e[0]    = (cnt == 0);
    addr = ST; we = 1'b0;
    #1;
    chk(nm, rdata, e);
    addr = '0;
  endtask

  task automatic drain();
    force_busy = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    repeat (12) tick();
    chk("drain_all_sent", exp_q.size(), 0);
    occ = 0;
    check_status("status_after_drain", 0, 2'd0);
  endtask

  task automatic rand_phase(input int n);
    force_busy = 1'b1;
    tick(); tick();
    for (int i = 0; i < n; i++) begin
      push_word($urandom, 1'b0);
      repeat ($urandom_range(0, 1)) tick();
    end
    check_status("status_filled", occ, 2'd0);
    if (exp_ovf && $urandom_range(0, 1) == 1) begin
      store(CT, 32'h2);
      exp_ovf = 1'b0; exp_to = 1'b0;
      chk("overflow_cleared", ovf, 0);
    end
    drain();
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_spi_data"}, spi_data, 0);
    chk({nm, "_spi_start"}, spi_start, 0);
    chk({nm, "_overflow"}, ovf, 0);
    chk({nm, "_timeout"}, tmo, 0);
    exp_ovf = 1'b0; exp_to = 1'b0;
    check_status({nm, "_status"}, 0, 2'd0);
  endtask

  initial begin
    int n;
    logic [31:0] d;
    rst = 1'b1; addr = '0; data = '0; we = 1'b0;
    force_busy = 1'b0; resp_en = 1'b1; resp_fixed = 1'b1;
    repeat (3) tick();
    check_reset("reset");
    rst = 1'b0;
    tick();

    // Single word into an empty idle queue: start two cycles after the store.
    exp_q.push_back(32'hA5A5_0001);
    store(TX, 32'hA5A5_0001);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n++;
      if (spi_start) break;
    end
    chk("start_latency", n, 2);
    chk("empty_after_pop", empty, 1);
    repeat (15) tick();
    check_status("status_after_single", 0, 2'd0);
    resp_fixed = 1'b0;

    // Nine stores while busy: ninth dropped, overflow set, then cleared.
    force_busy = 1'b1;
    tick(); tick();
    for (int i = 1; i <= 9; i++) push_word(32'(i), 1'b0);
    check_status("status_full", 8, 2'd0);
    chk("overflow_set", ovf, 1);
    store(CT, 32'h2);
    exp_ovf = 1'b0;
    check_status("status_ovf_cleared", 8, 2'd0);
    // Full queue popping in the same cycle as a store: store is kept.
    force_busy = 1'b0;
    push_word(32'hCAFE_0009, 1'b1);
    check_status("status_full_pop_push", 8, 2'd1);
    drain();

    // Five entries visible in status while idle.
    force_busy = 1'b1;
    tick(); tick();
    for (int i = 0; i < 5; i++) push_word($urandom, 1'b0);
    check_status("status_five", 5, 2'd0);
    drain();

    // Flush during WAIT_DONE: current transfer completes, nothing else launches.
    resp_en = 1'b0;
    force_busy = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) push_word($urandom, 1'b0);
    force_busy = 1'b0;
    tick();
    force_busy = 1'b1;
    tick(); tick();
    check_status("status_wait_done", 2, 2'd3);
    store(CT, 32'h1);
    exp_q.delete();
    occ = 0;
    check_status("status_flushed", 0, 2'd3);
    force_busy = 1'b0;
    repeat (12) tick();
    check_status("status_after_flush", 0, 2'd0);
    resp_en = 1'b1;

    for (int p = 0; p < 6; p++) rand_phase($urandom_range(1, 11));

    // Busy never rises after a start.
    resp_en = 1'b0;
    d = $urandom;
    exp_q.push_back(d);
    store(TX, d);
    repeat (20) tick();
`ifdef SPI_TXQ_TIMEOUT_EN
    exp_to = 1'b1;
    chk("timeout_set", tmo, 1);
    check_status("status_timeout", 0, 2'd0);
    resp_en = 1'b1;
    d = $urandom;
    exp_q.push_back(d);
    store(TX, d);
    drain();
    store(CT, 32'h2);
    exp_to = 1'b0; exp_ovf = 1'b0;
    chk("timeout_cleared", tmo, 0);
`else
    chk("timeout_tied_low", tmo, 0);
    check_status("status_stuck_wait_busy", 0, 2'd2);
`endif
    // Reset while a transfer is outstanding.
    rst = 1'b1;
    tick();
    check_reset("mid_reset");
    rst = 1'b0;
    tick();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errs);
    $fatal(1);
  end
endmodule
